// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues word fetches under a credit limit,
// buffers returned words with their PCs and hands them to decode over valid/ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];

  logic          grant;
  logic          resp_any;
  logic          resp_keep;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic [CW:0]   in_flight;
  logic [CW:0]   credit_used;

  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign in_flight   = {1'b0, outstanding_q} + {1'b0, discard_q};

  assign imem_req   = credit_used < DEPTH_C;
  assign imem_addr  = pc_q;
  assign inst_valid = count_q != '0;
  assign inst_data  = mem_data_q[rd_ptr_q];
  assign inst_pc    = mem_pc_q[rd_ptr_q];

  // A response with nothing in flight is a protocol violation and is ignored entirely.
  assign grant     = imem_req && imem_gnt;
  assign resp_any  = imem_rvalid && (in_flight != '0);
  assign resp_drop = resp_any && (discard_q != '0);
  assign resp_keep = resp_any && (discard_q == '0);
  assign pop       = inst_valid && inst_ready;
  assign push      = resp_keep && !redirect_valid;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    if (redirect_valid) begin
      pc_d          = {redirect_pc[31:2], 2'b00};
      resp_pc_d     = {redirect_pc[31:2], 2'b00};
      outstanding_d = '0;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      // Everything still in flight, including a grant taken this cycle, becomes stale.
      discard_d     = discard_q + outstanding_q + CW'(grant) - CW'(resp_any);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CW'(grant) - CW'(resp_keep);
      if (resp_drop) begin
        discard_d = discard_q - CW'(1);
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(resp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else if (push) begin
      mem_pc_q[wr_ptr_q]   <= resp_pc_q;
      mem_data_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: in-order memory model with variable latency and a
// scoreboard of the architectural instruction stream expected at the decode port.
module tb_inst_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  inst_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;

  mreq_t       memq[$];
  exp_t        expq[$];
  logic [31:0] exp_pc = RPC;
  bit          chk_redir = 1'b0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100;
  bit          redir_pend = 1'b0;
  logic [31:0] redir_target = '0;

  // Memory / execute / decode driver, inputs change 1 time unit after the rising edge
  initial begin
    int d;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
      inst_ready = int'($urandom_range(99)) < rdy_pct;
      if (!rst) begin
        memq.delete();
        last_due = 0;
        continue;
      end
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memq[0].addr ^ KEY;
        void'(memq.pop_front());
      end
      if (imem_req && int'($urandom_range(99)) < gnt_pct) begin
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        imem_gnt = 1'b1;
        memq.push_back('{imem_addr, d});
      end
      if (redir_pend && memq.size() <= 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_target;
        redir_pend     = 1'b0;
      end
    end
  end

  // Scoreboard: non-stale grants define the expected stream, decode handshakes consume it
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (chk_redir) begin
        chk_redir = 1'b0;
        check("redir_valid_low", 32'(inst_valid), 32'd0);
        if (imem_req) check("redir_addr", imem_addr, exp_pc);
      end
      if (inst_valid && inst_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst: got pc %h data %h, expected no instruction", inst_pc, inst_data);
        end else begin
          e = expq.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_data", inst_data, e.data);
        end
      end
      if (redirect_valid) begin
        expq.delete();
        exp_pc    = {redirect_pc[31:2], 2'b00};
        chk_redir = 1'b1;
      end else if (imem_req && imem_gnt) begin
        check("imem_addr", imem_addr, exp_pc);
        expq.push_back('{exp_pc, exp_pc ^ KEY});
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic do_redirect(input logic [31:0] t);
    int n;
    n = 0;
    redir_target = t;
    redir_pend   = 1'b1;
    while (redir_pend && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (redir_pend) begin
      checks++;
      failures++;
      redir_pend = 1'b0;
      $display("FAIL redirect_timeout: got pending after %0d cycles, expected issued", n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_addr", imem_addr, RPC);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_data", inst_data, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    #1 rst = 1'b1;

    // Sequential fetch: first instruction two cycles after the first grant, then one per cycle
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("seq_valid_timing", 32'(inst_valid), 32'(k >= 2));
    end

    rdy_pct = 0;
    repeat (10) @(negedge clk);
    check("bp_req_low", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_buffered", 32'(expq.size()), DEPTH);
    rdy_pct = 100;
    repeat (10) @(negedge clk);

    lat_min = 3; lat_max = 3;
    repeat (8) @(negedge clk);
    do_redirect(32'h0000_2003);
    repeat (15) @(negedge clk);

    lat_min = 1; lat_max = 1;
    repeat (6) @(negedge clk);
    do_redirect(32'h0000_3000);
    repeat (10) @(negedge clk);

    do_redirect(32'hFFFF_FFF8);
    repeat (10) @(negedge clk);

    lat_min = 1; lat_max = 4; gnt_pct = 70; rdy_pct = 60;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(60, 10)) @(negedge clk);
      do_redirect($urandom);
    end
    repeat (20) @(negedge clk);

    lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 0;
    repeat (10) @(negedge clk);
    check("full_before_reset", 32'(inst_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_addr", imem_addr, RPC);
    check("mid_rst_req", 32'(imem_req), 32'd1);
    expq.delete();
    exp_pc    = RPC;
    chk_redir = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    rdy_pct = 100;
    repeat (20) @(negedge clk);

    gnt_pct = 0;
    repeat (20) @(negedge clk);
    check("drain_empty", 32'(expq.size()), 32'd0);
    check("drain_valid", 32'(inst_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage that sits directly upstream of `cpu_core`'s decode input. It owns the program counter and issues sequential word requests to instruction memory over a request/grant/response interface. Returned instruction words are buffered with their PCs in a small FIFO and presented to decode over a valid/ready handshake. A redirect from execute flushes the buffer and discards in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2. Also the credit limit on outstanding plus buffered fetches.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `imem_req` output 1: fetch request. Driven from registered state only.
- `imem_addr` output 32: word address of the request; bits [1:0] are always 0.
- `imem_gnt` input 1: memory accepts the request this cycle; meaningful only when `imem_req` is high.
- `imem_rvalid` input 1: response valid. Responses return in order, one per grant, at least 1 cycle after the grant.
- `imem_rdata` input 32: instruction word.
- `redirect_valid` input 1: redirect PC, one-cycle pulse from execute.
- `redirect_pc` input 32: target address; bits [1:0] are ignored and treated as 0.
- `inst_valid` output 1: FIFO head valid.
- `inst_data` output 32: head instruction.
- `inst_pc` output 32: PC of the head instruction.
- `inst_ready` input 1: decode accepts the head this cycle.

## Operation
- **State**
  - `pc`: next request address.
  - `resp_pc`: PC of the next kept response.
  - `outstanding`: granted requests not yet returned, that will be kept.
  - `discard`: stale responses still to drop.
  - FIFO: `{pc, data}`, with `count`.
  - Counters are $clog2(DEPTH)+1 bits wide.
- **Request issue.** `imem_req = (outstanding + count < DEPTH)`. `imem_addr = pc`.
- **Grant without redirect.** `pc += 4` (32-bit wrap; 0xFFFF_FFFC wraps to 0) and `outstanding++`.
- **Response handling**
  - If `discard > 0`: drop the response and `discard--`.
  - Otherwise: write `{resp_pc, imem_rdata}` into the FIFO, then `resp_pc += 4` and `outstanding--`.
  - Credit guarantees the FIFO never overflows.
- **Pop.** When `inst_valid && inst_ready`, advance the head and `count--`.
- **Simultaneous push and pop** leave `count` unchanged.
- **Redirect (priority over everything else in that cycle)**
  - Flush the FIFO: `count = 0`.
  - `pc = resp_pc = {redirect_pc[31:2], 2'b00}`.
  - `outstanding = 0`.
  - `discard` = `discard + outstanding + (imem_req && imem_gnt) − (imem_rvalid ? 1 : 0)`.
  - A grant in the redirect cycle is therefore counted as stale.
  - A response in the redirect cycle is dropped.
  - Any pop in the redirect cycle still completes for decode, but execute owns squashing it.
- **Protocol violation.** `imem_rvalid` while `outstanding + discard == 0` is ignored: no write, no counter change.

## Timing
- **Reset values:**
  - `imem_req = 1`, `imem_addr = RESET_PC`.
  - `inst_valid = 0`, `inst_data = 0`, `inst_pc = 0`.
  - All counters 0; `pc = resp_pc = RESET_PC`.
- **Latency.** Response kept in cycle N gives `inst_valid` high in N+1 (registered FIFO, show-ahead head).
- **Throughput.** With 1-cycle memory, always-grant and `inst_ready` tied high, the block sustains one instruction per cycle when `DEPTH ≥ 4`.
- **Redirect pulse in cycle N:**
  - `inst_valid = 0` in N+1.
  - `imem_req` with `imem_addr = redirect_pc` in N+1 (if credit allows).
  - The first redirected instruction appears no earlier than N+3 with 1-cycle memory.
- **Back-to-back redirects.** Each redirect reloads `pc`. `discard` accumulates, so no stale response is ever written.
- **`rst` asserted mid-transfer.** Returns to reset values immediately. Responses arriving after reset deassertion for pre-reset requests are a system error and are not handled.

## Test plan
- **Reset and sequential fetch.** Release reset with `RESET_PC=0x100`, 1-cycle memory returning `addr^0xA5A5_0000`, `inst_ready=1` -> `inst_pc` is 0x100, 0x104, 0x108… on consecutive cycles, with matching `inst_data`, starting 2 cycles after the first grant.
- **Backpressure.** Hold `inst_ready=0` for 10 cycles -> exactly `DEPTH` (4) entries buffered, `imem_req` low, no loss. Release -> PCs remain in order.
- **Redirect with in-flight requests.** 3-cycle memory latency, 3 outstanding requests, pulse `redirect_pc=0x2003` -> the 3 stale responses are dropped, and the next `inst_pc` is 0x2000 followed by 0x2004.
- **Simultaneous events.** Redirect in the same cycle as a grant and a response -> the granted request is counted stale, and no instruction from the old stream ever reaches `inst_valid`.
- **Wrap-around.** Redirect to 0xFFFF_FFF8 -> `inst_pc` sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- **Reset mid-operation.** Assert `rst` low asynchronously with a full FIFO -> `inst_valid` drops immediately, and after release `imem_addr = RESET_PC`.
